// File: rtl/watch_set_ctrl.sv
// Watch timekeeping and time-set controller: six BCD digits advanced by a 1 Hz
// enable in RUN, frozen and edited digit-by-digit (with blink) in SET.
module watch_set_ctrl #(
    parameter int BLINK_DIV = 3000000,
    parameter int IDLE_SEC  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hrs0,
    output logic [3:0] hrs1,
    output logic [5:0] digit_sel,
    output logic [5:0] blank,
    output logic       set_mode
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (IDLE_SEC > 0) ? $clog2(IDLE_SEC + 1) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(IDLE_SEC);

    // index 0 = sec0 ... index 5 = hrs1, matching digit_sel bit order
    typedef logic [5:0][3:0] time_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t        state_q, state_d;
    time_t         time_q, time_d;
    logic [5:0]    sel_q, sel_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          hidden_q, hidden_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [5:0]    blank_q;

    function automatic logic [3:0] digit_max(input int idx, input logic [3:0] h1);
        logic [3:0] mx;
        case (idx)
            0, 2:    mx = 4'd9;
            1, 3:    mx = 4'd5;
            4:       mx = (h1 == 4'd2) ? 4'd3 : 4'd9;
            default: mx = 4'd2;
        endcase
        return mx;
    endfunction

    function automatic time_t advance(input time_t t);
        time_t n;
        n = t;
        if (t[0] != 4'd9) begin
            n[0] = t[0] + 4'd1;
        end else begin
            n[0] = 4'd0;
            if (t[1] != 4'd5) begin
                n[1] = t[1] + 4'd1;
            end else begin
                n[1] = 4'd0;
                if (t[2] != 4'd9) begin
                    n[2] = t[2] + 4'd1;
                end else begin
                    n[2] = 4'd0;
                    if (t[3] != 4'd5) begin
                        n[3] = t[3] + 4'd1;
                    end else begin
                        n[3] = 4'd0;
                        // hours roll 23 -> 00, otherwise plain BCD ripple
                        if (t[5] == 4'd2 && t[4] == 4'd3) begin
                            n[5] = 4'd0;
                            n[4] = 4'd0;
                        end else if (t[4] == 4'd9) begin
                            n[4] = 4'd0;
                            n[5] = t[5] + 4'd1;
                        end else begin
                            n[4] = t[4] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic time_t edit(input time_t t, input logic [5:0] sel, input logic up);
        time_t      n;
        logic [3:0] mx;
        n  = t;
        mx = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (sel[i]) begin
                mx = digit_max(i, t[5]);
                if (up) begin
                    n[i] = (t[i] >= mx) ? 4'd0 : t[i] + 4'd1;
                end else begin
                    n[i] = (t[i] == 4'd0 || t[i] > mx) ? mx : t[i] - 4'd1;
                end
            end
        end
        // raising hrs1 to 2 may leave hrs0 above 3
        if (n[5] == 4'd2 && n[4] > 4'd3) begin
            n[4] = 4'd3;
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            time_q   <= '0;
            sel_q    <= 6'b000001;
            blink_q  <= '0;
            hidden_q <= 1'b0;
            idle_q   <= '0;
            blank_q  <= '0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            sel_q    <= sel_d;
            blink_q  <= blink_d;
            hidden_q <= hidden_d;
            idle_q   <= idle_d;
            blank_q  <= hidden_d ? sel_d : 6'b000000;
        end
    end

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        sel_d    = sel_q;
        blink_d  = blink_q;
        hidden_d = hidden_q;
        idle_d   = idle_q;

        case (state_q)
            ST_RUN: begin
                blink_d  = '0;
                hidden_d = 1'b0;
                idle_d   = '0;
                if (tick) begin
                    time_d = advance(time_q);
                end
                if (btn_mode) begin
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                if (blink_q == BLINK_LAST) begin
                    blink_d  = '0;
                    hidden_d = ~hidden_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
                if (tick && idle_q != IDLE_LIMIT) begin
                    idle_d = idle_q + 1'b1;
                end

                // one action per cycle, highest priority first
                if (btn_mode || idle_q == IDLE_LIMIT) begin
                    state_d  = ST_RUN;
                    blink_d  = '0;
                    hidden_d = 1'b0;
                    idle_d   = '0;
                end else if (btn_left || btn_right || btn_up || btn_down) begin
                    blink_d  = '0;
                    hidden_d = 1'b0;
                    idle_d   = '0;
                    if (btn_left) begin
                        sel_d = {sel_q[4:0], sel_q[5]};
                    end else if (btn_right) begin
                        sel_d = {sel_q[0], sel_q[5:1]};
                    end else if (btn_up) begin
                        time_d = edit(time_q, sel_q, 1'b1);
                    end else begin
                        time_d = edit(time_q, sel_q, 1'b0);
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign sec0      = time_q[0];
    assign sec1      = time_q[1];
    assign min0      = time_q[2];
    assign min1      = time_q[3];
    assign hrs0      = time_q[4];
    assign hrs1      = time_q[5];
    assign digit_sel = sel_q;
    assign blank     = blank_q;
    assign set_mode  = (state_q == ST_SET);

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Timekeeping and time-set controller for the digital watch.
- Holds the six BCD time digits and advances them on a 1 Hz enable in RUN mode.
- In SET mode it freezes time and lets the user select a digit (left/right), edit it (up/down) and blink it.
- Sits between the debounce pulses / tick generator and the dec7 decoders plus seg_com scan logic.

Parameters:
- BLINK_DIV, 3000000, clk cycles per blink half-period (0.5 s at 6 MHz).
- IDLE_SEC, 30, number of tick pulses with no button activity in SET before auto-return to RUN.

Ports:
- clk  input  1  system clock (clk_6mhz domain)
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  1 Hz enable, one-cycle pulse
- btn_mode  input  1  one-cycle debounced pulse, toggles RUN/SET
- btn_left  input  1  one-cycle pulse, select more-significant digit
- btn_right  input  1  one-cycle pulse, select less-significant digit
- btn_up  input  1  one-cycle pulse, increment selected digit
- btn_down  input  1  one-cycle pulse, decrement selected digit
- sec0, sec1, min0, min1, hrs0, hrs1  output  4 each  BCD time digits
- digit_sel  output  6  one-hot selected digit; bit0=sec0 … bit5=hrs1
- blank  output  6  per-digit blank request, same bit order
- set_mode  output  1  1 = SET state

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - all digits 0 (00:00:00), state RUN, set_mode 0.
  - digit_sel 6'b000001, blank 0.
  - blink counter 0, blink phase visible, idle counter 0.
- All registers update on posedge clk. Outputs are registered; an action is visible 1 cycle after its input pulse.
- States: RUN, SET.
- RUN:
  - On tick, increment with carry: sec0 9→0 carries to sec1; sec1 5→0 carries to min0; min0 9→0 carries to min1; min1 5→0 carries to hours.
  - Hours are 00–23: 23:59:59 + tick → 00:00:00. 09→10 and 19→20 ripple normally.
  - left/right/up/down are ignored.
  - btn_mode → SET. digit_sel is kept, blink counter cleared, phase visible, idle counter cleared.
  - A tick in the same cycle as btn_mode is applied, then SET is entered.
- SET:
  - tick does not advance time; it only increments the idle counter.
  - Pulse priority when simultaneous: btn_mode > left > right > up > down. Exactly one action per cycle; the lower-priority pulses in that cycle are dropped.
  - btn_mode → RUN. The seconds prescale lives outside this block and is not reset.
  - left rotates digit_sel toward the MSB: bit5 wraps to bit0.
  - right rotates toward the LSB: bit0 wraps to bit5.
  - up/down edit the selected digit within its limits:
    - sec0, min0: 0–9.
    - sec1, min1: 0–5.
    - hrs1: 0–2.
    - hrs0: 0–9 when hrs1<2, 0–3 when hrs1=2.
  - up at max wraps to 0; down at 0 wraps to the current max. No carry to neighbouring digits.
  - Clamp: any edit that leaves hrs1=2 with hrs0>3 forces hrs0=3 in the same update.
  - Any left/right/up/down clears the idle counter, clears the blink counter and forces phase visible.
  - Idle timeout: when the idle counter reaches IDLE_SEC, the next cycle returns to RUN. A tick arriving in that same cycle is not applied.
- Blink:
  - In SET, the counter runs 0..BLINK_DIV-1; the phase toggles at wrap.
  - blank = digit_sel when phase is hidden, else 0.
  - In RUN, blank = 0, the counter is held at 0 and the phase is visible.
- Reset asserted mid-edit aborts immediately to the reset values. Partially edited time is discarded.
- Digits never hold a value outside their legal range under any input sequence.

Test Plan:
1. Release rst_n → 00:00:00, set_mode 0, digit_sel 000001, blank 0. Assert rst_n low asynchronously mid-SET → same values without a clk edge.
2. Preload 23:59:59 via SET edits, btn_mode to RUN, 1 tick → 00:00:00. Preload 09:59:59, 1 tick → 10:00:00.
3. SET, time 19:00:00, select hrs1 (5× left), up → hrs1 2, hrs0 clamped to 3 (23:00:00). Up again → hrs1 0 (03:00:00).
4. SET, select sec1=0, down → 5. Select hrs0 with hrs1=2, down from 0 → 3. Right from digit_sel 000001 → 100000.
5. SET, btn_left and btn_up in the same cycle → only digit_sel rotates, value unchanged. btn_mode with btn_up → RUN, value unchanged. Ticks during SET leave the time frozen.
6. IDLE_SEC=3, BLINK_DIV=4: enter SET → blank toggles between 0 and digit_sel every 4 cycles. After 3 ticks with no buttons → set_mode 0, blank 0, the following tick advances the time.
